// File: rtl/basket_access_sequencer_pkg.sv
// Shared definitions for the basket access sequencer.
//   - default sizing (entries, ProductID width, quantity width)
//   - error codes reported on err_code
//   - sequencer state encodings (plain constants so they can be shared with legacy code)
//   - grant selector used by the IDLE arbiter
// A RAM entry is packed as {id, qty}: qty occupies the low QTY_W bits, id the bits above it.
package basket_access_sequencer_pkg;

   localparam int DEF_DEPTH = 8;
   localparam int DEF_ID_W  = 4;
   localparam int DEF_QTY_W = 4;

   localparam logic [1:0] ERR_FULL    = 2'b01;
   localparam logic [1:0] ERR_BAD_IDX = 2'b10;

   localparam logic [3:0] ST_IDLE    = 4'd0;
   localparam logic [3:0] ST_ADD_RD  = 4'd1;
   localparam logic [3:0] ST_ADD_CHK = 4'd2;
   localparam logic [3:0] ST_ADD_WR  = 4'd3;
   localparam logic [3:0] ST_ADD_NEW = 4'd4;
   localparam logic [3:0] ST_CNL_RD  = 4'd5;
   localparam logic [3:0] ST_CNL_WR  = 4'd6;
   localparam logic [3:0] ST_CNL_END = 4'd7;
   localparam logic [3:0] ST_DISP_RD = 4'd8;

   typedef enum logic [2:0] {
      GNT_NONE,
      GNT_CLR,
      GNT_CNL,
      GNT_ADD,
      GNT_DISP
   } grant_t;

endpackage

// File: rtl/basket_access_sequencer_if.sv
// Bundle between the basket sequencer and its neighbours (sale-terminal FSM, VGA reader, entry RAM).
//   slave  : the sequencer's view (requests and mem_rdata in, status/display/RAM controls out)
//   master : the surrounding system's view (the reverse)
// Request pulses: add_req/add_id/add_qty, cnl_req/cnl_idx, clr_req, disp_req/disp_idx.
// Display result: disp_valid, disp_hit, disp_id, disp_qty.
// RAM port: mem_addr, mem_we, mem_wdata {id,qty}, mem_rdata (one-cycle read latency).
// Status: BasketProductNum, busy, done, err/err_code, drop.
interface basket_access_sequencer_if #(
   parameter int DEPTH = basket_access_sequencer_pkg::DEF_DEPTH,
   parameter int ID_W  = basket_access_sequencer_pkg::DEF_ID_W,
   parameter int QTY_W = basket_access_sequencer_pkg::DEF_QTY_W
) ();

   localparam int ADDR_W = $clog2(DEPTH);
   localparam int CNT_W  = $clog2(DEPTH + 1);

   logic                    add_req;
   logic [ID_W-1:0]         add_id;
   logic [QTY_W-1:0]        add_qty;
   logic                    cnl_req;
   logic [ADDR_W-1:0]       cnl_idx;
   logic                    clr_req;
   logic                    disp_req;
   logic [ADDR_W-1:0]       disp_idx;

   logic                    disp_valid;
   logic                    disp_hit;
   logic [ID_W-1:0]         disp_id;
   logic [QTY_W-1:0]        disp_qty;

   logic [ADDR_W-1:0]       mem_addr;
   logic                    mem_we;
   logic [ID_W+QTY_W-1:0]   mem_wdata;
   logic [ID_W+QTY_W-1:0]   mem_rdata;

   logic [CNT_W-1:0]        BasketProductNum;
   logic                    busy;
   logic                    done;
   logic                    err;
   logic [1:0]              err_code;
   logic                    drop;

   modport slave (
      input  add_req, add_id, add_qty, cnl_req, cnl_idx, clr_req, disp_req, disp_idx, mem_rdata,
      output disp_valid, disp_hit, disp_id, disp_qty, mem_addr, mem_we, mem_wdata,
             BasketProductNum, busy, done, err, err_code, drop
   );

   modport master (
      output add_req, add_id, add_qty, cnl_req, cnl_idx, clr_req, disp_req, disp_idx, mem_rdata,
      input  disp_valid, disp_hit, disp_id, disp_qty, mem_addr, mem_we, mem_wdata,
             BasketProductNum, busy, done, err, err_code, drop
   );

endinterface

// File: rtl/basket_access_sequencer_req_pending_latch.sv
// One pending-request slot: a flag, the operand captured with the request, and a drop pulse.
//   clk, rst   : clock, asynchronous active-high reset
//   req        : one-cycle request pulse
//   operand    : request operand, sampled only with req
//   clear      : slot is being granted or flushed this cycle
//   pending    : request waiting for service
//   operand_q  : operand of the waiting request
//   drop       : pulse, a request arrived while one of the same type was still waiting
// A request arriving in the same cycle the slot is cleared is kept, since it is newer than the
// one being consumed.
module basket_access_sequencer_req_pending_latch #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req,
   input  logic [W-1:0] operand,
   input  logic         clear,
   output logic         pending,
   output logic [W-1:0] operand_q,
   output logic         drop
);

   logic busy_slot;
   assign busy_slot = pending && !clear;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending   <= 1'b0;
         operand_q <= '0;
         drop      <= 1'b0;
      end else begin
         drop <= req && busy_slot;
         if (req && !busy_slot) begin
            pending   <= 1'b1;
            operand_q <= operand;
         end else if (clear) begin
            pending <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/basket_access_sequencer.sv
// Sole owner of the basket's single-port entry RAM.
// Queues add / cancel / clear / display requests and runs each as a multi-cycle RAM sequence,
// keeping entries 0..count-1 dense.
//   CLOCK_50 : system clock
//   RESET    : asynchronous, active-high reset
//   bus      : slave side of basket_access_sequencer_if (requests, display result, RAM port,
//              BasketProductNum, busy, done, err/err_code, drop)
// done, err and disp_valid are registered one-cycle pulses and update together with
// BasketProductNum. RAM controls are decoded from the current state.
module basket_access_sequencer
   import basket_access_sequencer_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int ID_W  = DEF_ID_W,
   parameter int QTY_W = DEF_QTY_W
) (
   input logic                         CLOCK_50,
   input logic                         RESET,
   basket_access_sequencer_if.slave    bus
);

   localparam int ADDR_W = $clog2(DEPTH);
   localparam int CNT_W  = $clog2(DEPTH + 1);
   localparam int ENT_W  = ID_W + QTY_W;

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
   localparam logic [QTY_W-1:0] QTY_MAX  = '1;

   // ---------------- request capture ----------------
   grant_t            grant;
   logic              add_pend, cnl_pend, clr_pend, disp_pend;
   logic              add_drop, cnl_drop, clr_drop, disp_drop;
   logic [ENT_W-1:0]  add_op;
   logic [ADDR_W-1:0] cnl_op;
   logic [ADDR_W-1:0] disp_op;
   logic              clr_op_unused;

   // A granted clear also discards waiting add and cancel requests.
   basket_access_sequencer_req_pending_latch #(.W(ENT_W)) u_add_slot (
      .clk       (CLOCK_50),
      .rst       (RESET),
      .req       (bus.add_req),
      .operand   ({bus.add_id, bus.add_qty}),
      .clear     ((grant == GNT_ADD) || (grant == GNT_CLR)),
      .pending   (add_pend),
      .operand_q (add_op),
      .drop      (add_drop)
   );

   basket_access_sequencer_req_pending_latch #(.W(ADDR_W)) u_cnl_slot (
      .clk       (CLOCK_50),
      .rst       (RESET),
      .req       (bus.cnl_req),
      .operand   (bus.cnl_idx),
      .clear     ((grant == GNT_CNL) || (grant == GNT_CLR)),
      .pending   (cnl_pend),
      .operand_q (cnl_op),
      .drop      (cnl_drop)
   );

   basket_access_sequencer_req_pending_latch #(.W(1)) u_clr_slot (
      .clk       (CLOCK_50),
      .rst       (RESET),
      .req       (bus.clr_req),
      .operand   (1'b0),
      .clear     (grant == GNT_CLR),
      .pending   (clr_pend),
      .operand_q (clr_op_unused),
      .drop      (clr_drop)
   );

   basket_access_sequencer_req_pending_latch #(.W(ADDR_W)) u_disp_slot (
      .clk       (CLOCK_50),
      .rst       (RESET),
      .req       (bus.disp_req),
      .operand   (bus.disp_idx),
      .clear     (grant == GNT_DISP),
      .pending   (disp_pend),
      .operand_q (disp_op),
      .drop      (disp_drop)
   );

   // ---------------- sequencer registers ----------------
   logic [3:0]        state;
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  j;
   logic [ID_W-1:0]   cur_id;
   logic [QTY_W-1:0]  cur_qty;
   logic [ADDR_W-1:0] cur_idx;
   logic              done_q, err_q, disp_valid_q, disp_hit_q;
   logic [1:0]        err_code_q;

   // ---------------- datapath helpers ----------------
   logic [ID_W-1:0]   rd_id;
   logic [QTY_W-1:0]  rd_qty;
   logic [QTY_W:0]    qty_sum;
   logic [QTY_W-1:0]  qty_merged;
   logic [CNT_W-1:0]  j_inc, j_inc2, cnl_ext, disp_ext, count_dec;

   assign rd_id      = bus.mem_rdata[ENT_W-1:QTY_W];
   assign rd_qty     = bus.mem_rdata[QTY_W-1:0];
   assign qty_sum    = {1'b0, rd_qty} + {1'b0, cur_qty};
   assign qty_merged = qty_sum[QTY_W] ? QTY_MAX : qty_sum[QTY_W-1:0];
   assign j_inc      = j + CNT_ONE;
   assign j_inc2     = j + CNT_TWO;
   assign cnl_ext    = CNT_W'(cnl_op);
   assign disp_ext   = CNT_W'(disp_op);
   assign count_dec  = count - CNT_ONE;

   // Fixed-priority arbiter, only evaluated while idle: clr > cnl > add > disp.
   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      grant = GNT_NONE;
      if (state == ST_IDLE) begin
         if (clr_pend)       grant = GNT_CLR;
         else if (cnl_pend)  grant = GNT_CNL;
         else if (add_pend)  grant = GNT_ADD;
         else if (disp_pend) grant = GNT_DISP;
      end
   end

   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         state        <= ST_IDLE;
         count        <= '0;
         j            <= '0;
         cur_id       <= '0;
         cur_qty      <= '0;
         cur_idx      <= '0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         err_code_q   <= 2'b00;
         disp_valid_q <= 1'b0;
         disp_hit_q   <= 1'b0;
      end else begin
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         err_code_q   <= 2'b00;
         disp_valid_q <= 1'b0;
         disp_hit_q   <= 1'b0;

         case (state)
            ST_IDLE: begin
               case (grant)
                  GNT_CLR: begin
                     count  <= '0;
                     done_q <= 1'b1;
                  end
                  GNT_CNL: begin
                     if (cnl_ext >= count) begin
                        err_q      <= 1'b1;
                        err_code_q <= ERR_BAD_IDX;
                     end else begin
                        j     <= cnl_ext;
                        // The last entry needs no shifting, only the count update.
                        state <= (cnl_ext == count_dec) ? ST_CNL_END : ST_CNL_RD;
                     end
                  end
                  GNT_ADD: begin
                     cur_id  <= add_op[ENT_W-1:QTY_W];
                     cur_qty <= add_op[QTY_W-1:0];
                     j       <= '0;
                     state   <= (count == '0) ? ST_ADD_NEW : ST_ADD_RD;
                  end
                  GNT_DISP: begin
                     if (disp_ext >= count) begin
                        disp_valid_q <= 1'b1;
                     end else begin
                        cur_idx <= disp_op;
                        state   <= ST_DISP_RD;
                     end
                  end
                  default: ;
               endcase
            end

            ST_ADD_RD: state <= ST_ADD_CHK;

            ST_ADD_CHK: begin
               if (rd_id == cur_id) begin
                  // Keep the merged quantity so ADD_WR writes it back to the same slot j.
                  cur_qty <= qty_merged;
                  state   <= ST_ADD_WR;
               end else begin
                  j     <= j_inc;
                  state <= (j_inc == count) ? ST_ADD_NEW : ST_ADD_RD;
               end
            end

            ST_ADD_WR: begin
               done_q <= 1'b1;
               state  <= ST_IDLE;
            end

            ST_ADD_NEW: begin
               if (count == CNT_FULL) begin
                  err_q      <= 1'b1;
                  err_code_q <= ERR_FULL;
               end else begin
                  count  <= count + CNT_ONE;
                  done_q <= 1'b1;
               end
               state <= ST_IDLE;
            end

            ST_CNL_RD: state <= ST_CNL_WR;

            ST_CNL_WR: begin
               j     <= j_inc;
               // Stop once the entry just moved came from the last valid slot.
               state <= (j_inc2 == count) ? ST_CNL_END : ST_CNL_RD;
            end

            ST_CNL_END: begin
               count  <= count_dec;
               done_q <= 1'b1;
               state  <= ST_IDLE;
            end

            ST_DISP_RD: begin
               disp_valid_q <= 1'b1;
               disp_hit_q   <= 1'b1;
               state        <= ST_IDLE;
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

   // ---------------- RAM port decode ----------------
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [ENT_W-1:0]  mem_wdata;

   always_comb begin
      mem_addr  = '0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      case (state)
         ST_ADD_RD, ST_ADD_CHK: mem_addr = j[ADDR_W-1:0];
         ST_ADD_WR: begin
            mem_addr  = j[ADDR_W-1:0];
            mem_we    = 1'b1;
            mem_wdata = {cur_id, cur_qty};
         end
         ST_ADD_NEW: begin
            if (count != CNT_FULL) begin
               mem_addr  = count[ADDR_W-1:0];
               mem_we    = 1'b1;
               mem_wdata = {cur_id, cur_qty};
            end
         end
         ST_CNL_RD: mem_addr = j_inc[ADDR_W-1:0];
         ST_CNL_WR: begin
            mem_addr  = j[ADDR_W-1:0];
            mem_we    = 1'b1;
            mem_wdata = bus.mem_rdata;
         end
         ST_DISP_RD: mem_addr = cur_idx;
         default: ;
      endcase
   end

   // ---------------- outputs ----------------
   assign bus.mem_addr         = mem_addr;
   assign bus.mem_we           = mem_we;
   assign bus.mem_wdata        = mem_wdata;
   assign bus.BasketProductNum = count;
   assign bus.busy             = (state != ST_IDLE);
   assign bus.done             = done_q;
   assign bus.err              = err_q;
   assign bus.err_code         = err_code_q;
   assign bus.drop             = add_drop | cnl_drop | clr_drop | disp_drop;
   assign bus.disp_valid       = disp_valid_q;
   assign bus.disp_hit         = disp_hit_q;
   // The RAM output still holds the entry read in DISP_RD during the disp_valid cycle.
   assign bus.disp_id          = disp_hit_q ? rd_id  : '0;
   assign bus.disp_qty         = disp_hit_q ? rd_qty : '0;

endmodule

// File: tb/tb_basket_access_sequencer.sv
// Bench for basket_access_sequencer: directed requests, an entry-list model of the basket,
// an expected-event queue checked by one compare process, and a RAM model behind the port.
module tb_basket_access_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   basket_access_sequencer_if bus ();

   basket_access_sequencer dut (
      .CLOCK_50 (clk),
      .RESET    (rst),
      .bus      (bus)
   );

   // Single-port RAM, one-cycle read latency, read-before-write.
   logic [7:0] ram [8];
   always @(posedge clk) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= ram[bus.mem_addr];
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
      end
   endtask

   // ---------------- basket model ----------------
   // kind: 0 done, 1 err, 2 display
   typedef struct {
      int kind;
      int code;
      int hit;
      int id;
      int qty;
      int cnt;
   } exp_t;

   exp_t exp_q[$];
   int   m_id  [8];
   int   m_qty [8];
   int   m_cnt   = 0;
   int   exp_cnt = 0;

   task automatic push_exp(input int kind, input int code, input int hit, input int id, input int qty);
      exp_t e;
      e.kind = kind; e.code = code; e.hit = hit; e.id = id; e.qty = qty; e.cnt = m_cnt;
      exp_q.push_back(e);
   endtask

   task automatic model_add(input int id, input int qty);
      int hit = -1;
      for (int i = 0; i < m_cnt; i++) if (m_id[i] == id) hit = i;
      if (hit >= 0) begin
         m_qty[hit] = (m_qty[hit] + qty > 15) ? 15 : m_qty[hit] + qty;
         push_exp(0, 0, 0, 0, 0);
      end else if (m_cnt == 8) begin
         push_exp(1, 1, 0, 0, 0);
      end else begin
         m_id[m_cnt]  = id;
         m_qty[m_cnt] = qty;
         m_cnt++;
         push_exp(0, 0, 0, 0, 0);
      end
   endtask

   task automatic model_cnl(input int idx);
      if (idx >= m_cnt) begin
         push_exp(1, 2, 0, 0, 0);
      end else begin
         for (int i = idx; i < m_cnt - 1; i++) begin
            m_id[i]  = m_id[i+1];
            m_qty[i] = m_qty[i+1];
         end
         m_cnt--;
         push_exp(0, 0, 0, 0, 0);
      end
   endtask

   task automatic model_clr();
      m_cnt = 0;
      push_exp(0, 0, 0, 0, 0);
   endtask

   task automatic model_disp(input int idx);
      if (idx < m_cnt) push_exp(2, 0, 1, m_id[idx], m_qty[idx]);
      else             push_exp(2, 0, 0, 0, 0);
   endtask

   // ---------------- compare process ----------------
   int   drops_seen = 0;
   int   we_cycles  = 0;
   exp_t cur_e;

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.drop)   drops_seen++;
         if (bus.mem_we) we_cycles++;
         if (bus.done || bus.err || bus.disp_valid) begin
            check("single_status_pulse", int'(bus.done) + int'(bus.err) + int'(bus.disp_valid), 1);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_event: done=%0b err=%0b disp_valid=%0b with nothing expected at %0t",
                        bus.done, bus.err, bus.disp_valid, $time);
            end else begin
               cur_e = exp_q.pop_front();
               check("event_kind", bus.done ? 0 : (bus.err ? 1 : 2), cur_e.kind);
               if (cur_e.kind == 1) check("err_code", int'(bus.err_code), cur_e.code);
               if (cur_e.kind == 2) begin
                  check("disp_hit", int'(bus.disp_hit), cur_e.hit);
                  check("disp_id",  int'(bus.disp_id),  cur_e.id);
                  check("disp_qty", int'(bus.disp_qty), cur_e.qty);
               end
               exp_cnt = cur_e.cnt;
            end
         end
         check("BasketProductNum", int'(bus.BasketProductNum), exp_cnt);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic pulse_add(input int id, input int qty);
      @(negedge clk);
      bus.add_req = 1'b1; bus.add_id = 4'(id); bus.add_qty = 4'(qty);
      @(negedge clk);
      bus.add_req = 1'b0;
   endtask

   task automatic pulse_cnl(input int idx);
      @(negedge clk);
      bus.cnl_req = 1'b1; bus.cnl_idx = 3'(idx);
      @(negedge clk);
      bus.cnl_req = 1'b0;
   endtask

   task automatic pulse_clr();
      @(negedge clk);
      bus.clr_req = 1'b1;
      @(negedge clk);
      bus.clr_req = 1'b0;
   endtask

   task automatic pulse_disp(input int idx);
      @(negedge clk);
      bus.disp_req = 1'b1; bus.disp_idx = 3'(idx);
      @(negedge clk);
      bus.disp_req = 1'b0;
   endtask

   // Waits until every expected event has been seen and the sequencer is idle; counts busy cycles.
   task automatic wait_quiet(output int busy_cyc);
      bit quiet = 1'b0;
      busy_cyc = 0;
      for (int k = 0; k < 300 && !quiet; k++) begin
         @(negedge clk);
         #1;
         if (bus.busy) busy_cyc++;
         if (exp_q.size() == 0 && !bus.busy) quiet = 1'b1;
      end
      if (!quiet) begin
         checks++;
         errors++;
         $display("FAIL wait_quiet_timeout: %0d events still expected at %0t", exp_q.size(), $time);
         exp_q.delete();
      end
   endtask

   task automatic do_add(input int id, input int qty, output int bc);
      model_add(id, qty); pulse_add(id, qty); wait_quiet(bc);
   endtask

   task automatic do_cnl(input int idx, output int bc);
      model_cnl(idx); pulse_cnl(idx); wait_quiet(bc);
   endtask

   task automatic do_clr(output int bc);
      model_clr(); pulse_clr(); wait_quiet(bc);
   endtask

   task automatic do_disp(input int idx, output int bc);
      model_disp(idx); pulse_disp(idx); wait_quiet(bc);
   endtask

   task automatic check_ram();
      for (int i = 0; i < m_cnt; i++) check("ram_entry", int'(ram[i]), m_id[i] * 16 + m_qty[i]);
   endtask

   // ---------------- directed sequence ----------------
   int bc;
   int we0;

   initial begin
      bus.add_req = 1'b0; bus.add_id = '0; bus.add_qty = '0;
      bus.cnl_req = 1'b0; bus.cnl_idx = '0;
      bus.clr_req = 1'b0;
      bus.disp_req = 1'b0; bus.disp_idx = '0;

      repeat (3) @(negedge clk);
      check("reset_busy",  int'(bus.busy), 0);
      check("reset_count", int'(bus.BasketProductNum), 0);
      check("reset_we",    int'(bus.mem_we), 0);
      check("reset_done",  int'(bus.done), 0);
      check("reset_err",   int'(bus.err), 0);
      rst = 1'b0;

      // 1: add to an empty basket writes slot 0 one cycle after grant.
      model_add(3, 2);
      pulse_add(3, 2);
      @(negedge clk); #1;
      check("t1_we",    int'(bus.mem_we), 1);
      check("t1_addr",  int'(bus.mem_addr), 0);
      check("t1_wdata", int'(bus.mem_wdata), 8'h32);
      check("t1_done_early", int'(bus.done), 0);
      @(negedge clk); #1;
      check("t1_done",  int'(bus.done), 1);
      check("t1_count", int'(bus.BasketProductNum), 1);
      wait_quiet(bc);

      // 2: merge into the same id, then saturate.
      do_add(3, 2, bc);
      check("t2_merge", int'(ram[0]), 8'h34);
      do_add(3, 15, bc);
      check("t2_sat", int'(ram[0]), 8'h3F);
      check("t2_count", int'(bus.BasketProductNum), 1);

      // 3: fill to eight distinct ids, then one more is rejected as FULL after a full scan.
      for (int id = 1; id <= 8; id++) if (id != 3) do_add(id, 1, bc);
      check("t3_count", int'(bus.BasketProductNum), 8);
      we0 = we_cycles;
      do_add(9, 1, bc);
      check("t3_full_busy", bc, 17);
      check("t3_full_no_we", we_cycles - we0, 0);
      do_disp(2, bc);
      do_disp(7, bc);
      check_ram();

      // 4: cancel from the middle compacts the list.
      do_clr(bc);
      check("t4_clr_busy", bc, 0);
      for (int id = 1; id <= 5; id++) do_add(id, 1, bc);
      we0 = we_cycles;
      do_cnl(1, bc);
      check("t4_cnl_writes", we_cycles - we0, 3);
      check("t4_cnl_busy", bc, 7);
      check("t4_ram1", int'(ram[1]), 8'h31);
      check("t4_ram2", int'(ram[2]), 8'h41);
      check("t4_ram3", int'(ram[3]), 8'h51);
      do_cnl(7, bc);
      check("t4_bad_busy", bc, 0);
      do_add(5, 2, bc);
      check("t4_merge_busy", bc, 9);
      check("t4_merge_val", int'(ram[3]), 8'h53);
      do_cnl(3, bc);
      check("t4_last_busy", bc, 1);
      check_ram();

      // 5: requests during an add scan only pend; clear wins afterwards and flushes.
      we0 = drops_seen;
      model_add(9, 1);
      pulse_add(9, 1);
      @(negedge clk); bus.cnl_req = 1'b1; bus.cnl_idx = 3'd0;
      @(negedge clk); bus.cnl_req = 1'b0; bus.clr_req = 1'b1;
      model_clr();
      @(negedge clk); bus.clr_req = 1'b0; bus.disp_req = 1'b1; bus.disp_idx = 3'd0;
      model_disp(0);
      @(negedge clk); bus.disp_req = 1'b0; bus.add_req = 1'b1; bus.add_id = 4'd6; bus.add_qty = 4'd1;
      @(negedge clk); bus.add_req = 1'b0;
      @(negedge clk); bus.add_req = 1'b1; bus.add_id = 4'd7;
      @(negedge clk); bus.add_req = 1'b0;
      wait_quiet(bc);
      repeat (3) @(negedge clk);
      check("t5_drops", drops_seen - we0, 1);
      check("t5_count", int'(bus.BasketProductNum), 0);
      check("t5_idle", int'(bus.busy), 0);

      // 6: reset in the middle of a cancel.
      for (int id = 1; id <= 4; id++) do_add(id, 2, bc);
      pulse_cnl(0);
      repeat (3) @(negedge clk);
      #2;
      rst = 1'b1;
      exp_q.delete();
      m_cnt = 0;
      exp_cnt = 0;
      #1;
      check("t6_busy",  int'(bus.busy), 0);
      check("t6_count", int'(bus.BasketProductNum), 0);
      check("t6_we",    int'(bus.mem_we), 0);
      check("t6_addr",  int'(bus.mem_addr), 0);
      check("t6_done",  int'(bus.done), 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk); #1;
      check("t6_idle_after", int'(bus.busy), 0);
      do_add(10, 5, bc);
      check("t6_add_busy", bc, 1);
      check("t6_slot0", int'(ram[0]), 8'hA5);
      check("t6_count_after", int'(bus.BasketProductNum), 1);

      check("no_extra_drops", drops_seen - we0, 1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
